// File: rtl/fp_pkg.sv
// Shared encodings for the FP special-operand path: operand class codes, op codes
// and a quiet-NaN pattern builder usable for any exponent/mantissa split.
package fp_pkg;

    localparam logic [2:0] CLS_ZERO      = 3'b000;
    localparam logic [2:0] CLS_INF       = 3'b001;
    localparam logic [2:0] CLS_SUBNORMAL = 3'b010;
    localparam logic [2:0] CLS_NORMAL    = 3'b011;
    localparam logic [2:0] CLS_NAN       = 3'b100;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam int QNAN_MAX_W = 64;

    // Default quiet NaN: sign set, exponent all-ones, mantissa MSB set, rest zero.
    // Returned right-aligned in a 64-bit word; the caller slices its own width.
    function automatic logic [QNAN_MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
        logic [QNAN_MAX_W-1:0] r;
        for (int i = 0; i < QNAN_MAX_W; i++) begin
            r[i] = (i >= man_w - 1) && (i <= exp_w + man_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: maps {exp, man} to a class code and flags
// signalling NaNs. The sign bit does not affect the class, so it is not an input.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] x,
    output logic [2:0]             cls,
    output logic                   snan
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = (x[MAN_W +: EXP_W] == '0);
    assign exp_ones = &x[MAN_W +: EXP_W];
    assign man_zero = (x[MAN_W-1:0] == '0);

    always_comb begin
        cls = CLS_NORMAL;
        if (exp_zero && man_zero)      cls = CLS_ZERO;
        else if (exp_zero)             cls = CLS_SUBNORMAL;
        else if (exp_ones && man_zero) cls = CLS_INF;
        else if (exp_ones)             cls = CLS_NAN;
    end

    assign snan = exp_ones && !man_zero && !x[MAN_W-1];

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage elastic resolver for zero/inf/NaN operand combinations ahead of the
// FP add/sub/mul datapath. Define FP_SPECIAL_STATS_EN to add saturating counters.
module fp_special_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_special,
    output logic         out_invalid,
`ifdef FP_SPECIAL_STATS_EN
    output logic [15:0]  stat_special_cnt,
    output logic [15:0]  stat_invalid_cnt,
`endif
    output logic [2:0]   out_type_a,
    output logic [2:0]   out_type_b
);

    localparam logic [QNAN_MAX_W-1:0] QN_FULL = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-1:0]          QN      = QN_FULL[W-1:0];

    function automatic logic [W-1:0] quieten(input logic [W-1:0] x);
        logic [W-1:0] r;
        r           = x;
        r[MAN_W-1]  = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] inf_word(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    logic         adv1;
    logic         adv2;
    logic [1:0]   op_s0;
    logic [W-1:0] b_s0;
    logic [2:0]   cls_a_s0, cls_b_s0;
    logic         snan_a_s0, snan_b_s0;

    logic         vld_p1;
    logic [1:0]   op_p1;
    logic [W-1:0] a_p1, b_p1;
    logic [2:0]   cls_a_p1, cls_b_p1;
    logic         snan_a_p1, snan_b_p1;

    logic [W-1:0] res_s1;
    logic         spec_s1, inv_s1;

    logic         vld_p2;
    logic [W-1:0] res_p2;
    logic         spec_p2, inv_p2;
    logic [2:0]   cls_a_p2, cls_b_p2;

    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    // Reserved op code collapses to add; subtraction becomes addition of -B.
    assign op_s0 = (in_op == OP_SUB || in_op == OP_MUL) ? in_op : OP_ADD;
    assign b_s0  = {in_b[W-1] ^ (op_s0 == OP_SUB), in_b[W-2:0]};

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .x    (in_a[W-2:0]),
        .cls  (cls_a_s0),
        .snan (snan_a_s0)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .x    (in_b[W-2:0]),
        .cls  (cls_b_s0),
        .snan (snan_b_s0)
    );

    // ---- stage S1: operands and classes ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv1) vld_p1 <= in_valid;
            if (adv2) vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            op_p1     <= op_s0;
            a_p1      <= in_a;
            b_p1      <= b_s0;
            cls_a_p1  <= cls_a_s0;
            cls_b_p1  <= cls_b_s0;
            snan_a_p1 <= snan_a_s0;
            snan_b_p1 <= snan_b_s0;
        end
    end

    logic sa, sb;
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sa     = a_p1[W-1];
    assign sb     = b_p1[W-1];
    assign nan_a  = (cls_a_p1 == CLS_NAN);
    assign nan_b  = (cls_b_p1 == CLS_NAN);
    assign inf_a  = (cls_a_p1 == CLS_INF);
    assign inf_b  = (cls_b_p1 == CLS_INF);
    assign zero_a = (cls_a_p1 == CLS_ZERO);
    assign zero_b = (cls_b_p1 == CLS_ZERO);

    always_comb begin
        res_s1  = '0;
        spec_s1 = 1'b0;
        inv_s1  = 1'b0;
        if (nan_a || nan_b) begin
            spec_s1 = 1'b1;
            inv_s1  = snan_a_p1 || snan_b_p1;
            if (nan_a && nan_b) begin
                if (a_p1[MAN_W-2:0] > b_p1[MAN_W-2:0])      res_s1 = quieten(a_p1);
                else if (b_p1[MAN_W-2:0] > a_p1[MAN_W-2:0]) res_s1 = quieten(b_p1);
                else                                         res_s1 = quieten({sa & sb, a_p1[W-2:0]});
            end else if (nan_a) begin
                res_s1 = quieten(a_p1);
            end else begin
                res_s1 = quieten(b_p1);
            end
        end else if (op_p1 == OP_MUL) begin
            if ((zero_a && inf_b) || (inf_a && zero_b)) begin
                spec_s1 = 1'b1;
                inv_s1  = 1'b1;
                res_s1  = QN;
            end else if (inf_a || inf_b) begin
                spec_s1 = 1'b1;
                res_s1  = inf_word(sa ^ sb);
            end else if (zero_a || zero_b) begin
                spec_s1 = 1'b1;
                res_s1  = {sa ^ sb, {(W-1){1'b0}}};
            end
        end else begin
            if (zero_a && zero_b) begin
                spec_s1 = 1'b1;
                res_s1  = {sa & sb, {(W-1){1'b0}}};
            end else if (zero_a) begin
                spec_s1 = 1'b1;
                res_s1  = b_p1;
            end else if (zero_b) begin
                spec_s1 = 1'b1;
                res_s1  = a_p1;
            end else if (inf_a && inf_b) begin
                spec_s1 = 1'b1;
                inv_s1  = (sa != sb);
                res_s1  = (sa == sb) ? a_p1 : QN;
            end else if (inf_a) begin
                spec_s1 = 1'b1;
                res_s1  = a_p1;
            end else if (inf_b) begin
                spec_s1 = 1'b1;
                res_s1  = b_p1;
            end
        end
    end

    // ---- stage S2: resolved result ----
    always_ff @(posedge clk) begin
        if (vld_p1 && adv2) begin
            res_p2   <= res_s1;
            spec_p2  <= spec_s1;
            inv_p2   <= inv_s1;
            cls_a_p2 <= cls_a_p1;
            cls_b_p2 <= cls_b_p1;
        end
    end

    // Data registers carry no reset; outputs are forced to zero while empty.
    assign out_valid   = vld_p2;
    assign out_result  = vld_p2 ? res_p2   : '0;
    assign out_special = vld_p2 && spec_p2;
    assign out_invalid = vld_p2 && inv_p2;
    assign out_type_a  = vld_p2 ? cls_a_p2 : '0;
    assign out_type_b  = vld_p2 ? cls_b_p2 : '0;

`ifdef FP_SPECIAL_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_special_cnt <= '0;
            stat_invalid_cnt <= '0;
        end else if (vld_p2 && out_ready) begin
            if (spec_p2) stat_special_cnt <= sat_inc16(stat_special_cnt);
            if (inv_p2)  stat_invalid_cnt <= sat_inc16(stat_invalid_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fp_special_pipe.sv
// Directed bench for fp_special_pipe (single precision): special-case vectors,
// latency, backpressure stability and asynchronous reset flush.
module tb_fp_special_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_special, out_invalid;
    logic [2:0]  out_type_a, out_type_b;
`ifdef FP_SPECIAL_STATS_EN
    logic [15:0] stat_special_cnt, stat_invalid_cnt;
`endif

    always #5 clk = ~clk;

    fp_special_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_special (out_special),
        .out_invalid (out_invalid),
`ifdef FP_SPECIAL_STATS_EN
        .stat_special_cnt (stat_special_cnt),
        .stat_invalid_cnt (stat_invalid_cnt),
`endif
        .out_type_a  (out_type_a),
        .out_type_b  (out_type_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        spec;
        logic        inv;
        logic [2:0]  ta;
        logic [2:0]  tb;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] bp_vals[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b1, 1'b1, 3'd1, 3'd1};
        vecs[1]  = '{2'b00, 32'h7FC00001, 32'h7FC00002, 32'h7FC00002, 1'b1, 1'b0, 3'd4, 3'd4};
        vecs[2]  = '{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b1, 1'b1, 3'd4, 3'd3};
        vecs[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 3'd0, 3'd0};
        vecs[4]  = '{2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 3'd0, 3'd0};
        vecs[5]  = '{2'b01, 32'h3F800000, 32'h00000000, 32'h3F800000, 1'b1, 1'b0, 3'd3, 3'd0};
        vecs[6]  = '{2'b10, 32'h00000000, 32'hFF800000, 32'hFFC00000, 1'b1, 1'b1, 3'd0, 3'd1};
        vecs[7]  = '{2'b10, 32'hBF800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 3'd3, 3'd1};
        vecs[8]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 3'd3, 3'd3};
        vecs[9]  = '{2'b00, 32'hFF800003, 32'h7FC00003, 32'h7FC00003, 1'b1, 1'b1, 3'd4, 3'd4};
        vecs[10] = '{2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 3'd3, 3'd1};
        vecs[11] = '{2'b11, 32'h40000000, 32'h80000000, 32'h40000000, 1'b1, 1'b0, 3'd3, 3'd0};
        vecs[12] = '{2'b01, 32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b1, 1'b1, 3'd1, 3'd1};
        vecs[13] = '{2'b10, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 3'd2, 3'd3};
        vecs[14] = '{2'b10, 32'h3F800000, 32'hFF800001, 32'hFFC00001, 1'b1, 1'b1, 3'd3, 3'd4};
        vecs[15] = '{2'b01, 32'h00000000, 32'h7FC00000, 32'hFFC00000, 1'b1, 1'b0, 3'd0, 3'd4};
        bp_vals[0] = 32'h3F800000;
        bp_vals[1] = 32'h40000000;
        bp_vals[2] = 32'h40400000;
        bp_vals[3] = 32'h40800000;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_ADD;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", out_result, 0);
        check("rst_special", out_special, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_op     = vecs[i].op;
            in_a      = vecs[i].a;
            in_b      = vecs[i].b;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1 check($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            check($sformatf("v%0d_early_valid", i), out_valid, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_result", i), out_result, vecs[i].res);
            check($sformatf("v%0d_special", i), out_special, vecs[i].spec);
            check($sformatf("v%0d_invalid", i), out_invalid, vecs[i].inv);
            check($sformatf("v%0d_type_a", i), out_type_a, vecs[i].ta);
            check($sformatf("v%0d_type_b", i), out_type_b, vecs[i].tb);
        end

        // Backpressure: 4 pairs, out_ready low for the first 3 cycles.
        begin
            int          sent = 0;
            int          got = 0;
            logic        acc;
            logic        hold_v = 1'b0;
            logic [40:0] held = '0;
            @(negedge clk);
            for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
                @(negedge clk);
                out_ready = (cyc >= 3);
                in_valid  = (sent < 4);
                in_op     = OP_ADD;
                in_a      = 32'h0;
                in_b      = bp_vals[(sent < 4) ? sent : 3];
                #1;
                if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
                if (hold_v && out_valid)
                    check("bp_stable", {out_result, out_special, out_invalid, out_type_a, out_type_b}, held);
                if (out_valid) begin
                    if (out_ready) begin
                        check($sformatf("bp_out%0d", got), out_result, bp_vals[got]);
                        got++;
                        hold_v = 1'b0;
                    end else begin
                        held   = {out_result, out_special, out_invalid, out_type_a, out_type_b};
                        hold_v = 1'b1;
                    end
                end
                acc = in_valid && in_ready;
                @(posedge clk);
                if (acc) sent++;
            end
            #1 in_valid = 1'b0;
            check("bp_count", got, 4);
        end

        // Reset with two entries in flight.
        begin
            int spurious = 0;
            @(negedge clk);
            out_ready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                in_valid = 1'b1;
                in_op    = OP_MUL;
                in_a     = 32'h00000000;
                in_b     = bp_vals[i];
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("pre_rst_valid", out_valid, 1);
            rst_n = 1'b0;
            #1;
            check("mid_rst_valid", out_valid, 0);
            check("mid_rst_in_ready", in_ready, 1);
            @(negedge clk);
            rst_n     = 1'b1;
            out_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (out_valid) spurious++;
            end
            check("post_rst_outputs", spurious, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
